// File: rtl/uart_pkg.sv
// ============================================================================
// Module   : uart_pkg
// Brief    : Shared UART constants, FSM state encodings and parity helper.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_pkg;

    localparam int BAUD_DIV   = 104;
    localparam int OVERSAMPLE = 16;
    localparam int FRAME_BITS = 11;
    localparam int ADDR_W     = 3;
    localparam int DATA_W     = 4;
    localparam int WORD_W     = 1 + ADDR_W + DATA_W;
    localparam int IDX_W      = $clog2(WORD_W);

    localparam int ST_W = 3;
    localparam logic [ST_W-1:0] ST_IDLE    = 3'd0;
    localparam logic [ST_W-1:0] ST_START   = 3'd1;
    localparam logic [ST_W-1:0] ST_PAYLOAD = 3'd2;
    localparam logic [ST_W-1:0] ST_PARITY  = 3'd3;
    localparam logic [ST_W-1:0] ST_STOP    = 3'd4;

    // Returns the bit that makes the total ones count over word+parity even.
    function automatic logic even_parity(input logic [WORD_W-1:0] i_word);
        return ^i_word;
    endfunction

endpackage

`default_nettype wire

// File: rtl/uart_baud_tick.sv
// ============================================================================
// Module   : uart_baud_tick
// Brief    : Enabled bit-period counter; flags the last cycle of each bit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_baud_tick #(
    parameter int CLKS_PER_BIT = 1664,
    parameter int CNT_W        = 11
) (
    input  logic clk,
    input  logic rst,
    input  logic i_en,
    output logic o_bit_end
);

    localparam logic [CNT_W-1:0] c_last = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             w_last;

    assign w_last    = (r_cnt == c_last);
    assign o_bit_end = i_en && w_last;

    // Wrapping at the bit end keeps the count at zero on every state entry.
    always_ff @(posedge clk) begin
        if (rst || !i_en) begin
            r_cnt <= '0;
        end else if (w_last) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

endmodule

`default_nettype wire

// File: rtl/uart_reply_tx.sv
// ============================================================================
// Module   : uart_reply_tx
// Brief    : 11-bit frame UART reply transmitter (start, R/W, addr, data,
//            even parity, stop), MSB first. Optional one-entry request
//            holding register enabled by `UART_TX_PENDING_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_reply_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = BAUD_DIV * OVERSAMPLE,
    parameter int CNT_W        = 11
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     tx_start,
    input  logic                     rw_bit,
    input  logic [ADDR_W+DATA_W-1:0] to_tx,
    output logic                     tx,
    output logic                     tx_busy,
    output logic                     tx_done,
    output logic                     tx_overrun
);

    logic [ST_W-1:0]   r_state, w_state_nxt;
    logic [WORD_W-1:0] r_shift, w_shift_nxt;
    logic [IDX_W-1:0]  r_bit_idx, w_idx_nxt;
    logic              r_par, w_par_nxt;
    logic              r_tx, r_busy, r_done, r_overrun;
    logic              w_tx_nxt, w_done_nxt;

    logic              w_bit_end;
    logic              w_free;
    logic              w_load_new;
    logic              w_load_pend;
    logic              w_load;
    logic              w_drop;
    logic [WORD_W-1:0] w_req;
    logic [WORD_W-1:0] w_load_word;

    uart_baud_tick #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .CNT_W        (CNT_W)
    ) u_baud (
        .clk       (clk),
        .rst       (rst),
        .i_en      (r_state != ST_IDLE),
        .o_bit_end (w_bit_end)
    );

    assign w_req  = {rw_bit, to_tx};
    // The line is free in IDLE and on the last stop-bit cycle, giving gapless frames.
    assign w_free = (r_state == ST_IDLE) || ((r_state == ST_STOP) && w_bit_end);
    assign w_load = w_load_new || w_load_pend;

`ifdef UART_TX_PENDING_EN
    logic              r_pend_vld;
    logic [WORD_W-1:0] r_pend_word;
    logic              w_store;

    assign w_load_pend = w_free && r_pend_vld;
    assign w_load_new  = tx_start && w_free && !r_pend_vld;
    assign w_store     = tx_start && !w_load_new && (!r_pend_vld || w_load_pend);
    assign w_drop      = tx_start && !w_load_new && !w_store;
    assign w_load_word = w_load_pend ? r_pend_word : w_req;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pend_vld  <= 1'b0;
            r_pend_word <= '0;
        end else if (w_store) begin
            r_pend_vld  <= 1'b1;
            r_pend_word <= w_req;
        end else if (w_load_pend) begin
            r_pend_vld  <= 1'b0;
        end
    end
`else
    assign w_load_pend = 1'b0;
    assign w_load_new  = tx_start && w_free;
    assign w_drop      = tx_start && !w_free;
    assign w_load_word = w_req;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_shift   <= '0;
            r_bit_idx <= '0;
            r_par     <= 1'b0;
            r_tx      <= 1'b1;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_shift   <= w_shift_nxt;
            r_bit_idx <= w_idx_nxt;
            r_par     <= w_par_nxt;
            r_tx      <= w_tx_nxt;
            r_busy    <= (w_state_nxt != ST_IDLE);
            r_done    <= w_done_nxt;
            r_overrun <= r_overrun | w_drop;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:    if (w_load) w_state_nxt = ST_START;
            ST_START:   if (w_bit_end) w_state_nxt = ST_PAYLOAD;
            ST_PAYLOAD: if (w_bit_end && (r_bit_idx == '0)) w_state_nxt = ST_PARITY;
            ST_PARITY:  if (w_bit_end) w_state_nxt = ST_STOP;
            ST_STOP:    if (w_bit_end) w_state_nxt = w_load ? ST_START : ST_IDLE;
            default:    w_state_nxt = ST_IDLE;
        endcase
    end

    // tx is registered from the next-state view so the line changes on the transition edge.
    always_comb begin
        w_shift_nxt = r_shift;
        w_par_nxt   = r_par;
        w_idx_nxt   = r_bit_idx;
        if (w_load) begin
            w_shift_nxt = w_load_word;
            w_par_nxt   = even_parity(w_load_word);
            w_idx_nxt   = IDX_W'(WORD_W - 1);
        end else if ((r_state == ST_PAYLOAD) && w_bit_end) begin
            w_idx_nxt   = r_bit_idx - IDX_W'(1);
        end

        w_done_nxt = (r_state == ST_STOP) && w_bit_end;

        case (w_state_nxt)
            ST_START:   w_tx_nxt = 1'b0;
            ST_PAYLOAD: w_tx_nxt = w_shift_nxt[w_idx_nxt];
            ST_PARITY:  w_tx_nxt = w_par_nxt;
            default:    w_tx_nxt = 1'b1;
        endcase
    end

    assign tx         = r_tx;
    assign tx_busy    = r_busy;
    assign tx_done    = r_done;
    assign tx_overrun = r_overrun;

endmodule

`default_nettype wire
